// File: rtl/johnson_seq_ctrl.sv
// Johnson counter sequencing controller: runs a 2*WIDTH-state Johnson register for a
// programmed number of revolutions, with hold/abort/preload, phase decode and code repair.
module johnson_seq_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 hold,
    input  logic                 abort,
    input  logic [7:0]           revs,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    output logic [WIDTH-1:0]     q,
    output logic [2*WIDTH-1:0]   phase,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           rev_cnt
);

    localparam int unsigned NSTATES = 2 * WIDTH;
    localparam int unsigned IDXW    = $clog2(NSTATES);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [7:0]       rev_cnt_q, rev_cnt_d;
    logic [7:0]       revs_q, revs_d;
    logic             err_q, err_d;

    logic [WIDTH-2:0] edges;
    logic [WIDTH-2:0] edges_m1;
    logic             legal;
    logic [IDXW-1:0]  ones;
    logic [IDXW-1:0]  idx;
    logic             wrap_code;
    logic [WIDTH-1:0] q_adv;
    logic [7:0]       rev_inc;

    // A legal Johnson code has at most one 0/1 boundary between adjacent bits.
    assign edges    = q_q[WIDTH-1:1] ^ q_q[WIDTH-2:0];
    assign edges_m1 = edges - {{(WIDTH-2){1'b0}}, 1'b1};
    assign legal    = ((edges & edges_m1) == '0);

    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + {{(IDXW-1){1'b0}}, q_q[i]};
        end
    end

    // MSB set means the falling half: index is NSTATES - ones, i.e. -ones modulo NSTATES.
    assign idx       = q_q[WIDTH-1] ? ({IDXW{1'b0}} - ones) : ones;
    assign wrap_code = (q_q == {1'b1, {(WIDTH-1){1'b0}}});
    assign q_adv     = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
    assign rev_inc   = rev_cnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        rev_cnt_d = rev_cnt_q;
        revs_d    = revs_q;
        err_d     = err_q | ~legal;

        case (state_q)
            StIdle: begin
                if (load) begin
                    q_d = load_val;
                end
                if (!abort && start) begin
                    state_d   = StRun;
                    revs_d    = revs;
                    rev_cnt_d = '0;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    q_d     = '0;
                end else if (hold) begin
                    q_d = q_q;
                end else if (!legal) begin
                    q_d = '0;
                end else begin
                    q_d = q_adv;
                    if (wrap_code) begin
                        rev_cnt_d = rev_inc;
                        if ((revs_q != 8'd0) && (rev_inc == revs_q)) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                q_d     = '0;
                state_d = StIdle;
            end
            default: begin
                q_d     = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            q_q       <= '0;
            rev_cnt_q <= '0;
            revs_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            rev_cnt_q <= rev_cnt_d;
            revs_q    <= revs_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        phase = '0;
        if (state_q == StRun && legal) begin
            phase[idx] = 1'b1;
        end
    end

    assign q       = q_q;
    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign err     = err_q;
    assign rev_cnt = rev_cnt_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl: a table-driven reference model predicts the
// outputs after every edge; a monitor compares them one time unit after the edge.
module tb_johnson_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        hold;
    logic        abort;
    logic [7:0]  revs;
    logic        load;
    logic [7:0]  load_val;
    logic [7:0]  q;
    logic [15:0] phase;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  rev_cnt;

    johnson_seq_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .hold     (hold),
        .abort    (abort),
        .revs     (revs),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .phase    (phase),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rev_cnt  (rev_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  q;
        logic [15:0] phase;
        logic        busy;
        logic        done;
        logic        err;
        logic [7:0]  rev_cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t mon_a;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: the 16 legal codes listed in sequence order.
    logic [7:0] codes [16];
    logic [7:0] m_q;
    int         m_mode;  // 0 idle, 1 run, 2 done
    logic [7:0] m_revs;
    logic [7:0] m_cnt;
    logic       m_err;

    function automatic int code_idx(input logic [7:0] v);
        for (int i = 0; i < 16; i++) begin
            if (codes[i] == v) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic h, input logic a,
                              input logic [7:0] rv, input logic l, input logic [7:0] lv);
        int   k;
        exp_t e;
        k = code_idx(m_q);
        if (r) begin
            m_q = 8'h00; m_mode = 0; m_cnt = 8'h00; m_revs = 8'h00; m_err = 1'b0;
        end else begin
            if (k < 0) m_err = 1'b1;
            if (m_mode == 0) begin
                if (l) m_q = lv;
                if (!a && s) begin
                    m_mode = 1; m_revs = rv; m_cnt = 8'h00;
                end
            end else if (m_mode == 1) begin
                if (a) begin
                    m_mode = 0; m_q = 8'h00;
                end else if (!h) begin
                    if (k < 0) begin
                        m_q = 8'h00;
                    end else begin
                        if (k == 15) begin
                            m_cnt = m_cnt + 8'd1;
                            if (m_revs != 0 && m_cnt == m_revs) m_mode = 2;
                        end
                        m_q = codes[(k + 1) % 16];
                    end
                end
            end else begin
                m_q = 8'h00; m_mode = 0;
            end
        end
        k = code_idx(m_q);
        e.q       = m_q;
        e.phase   = (m_mode == 1 && k >= 0) ? (16'h0001 << k) : 16'h0000;
        e.busy    = (m_mode == 1);
        e.done    = (m_mode == 2);
        e.err     = m_err;
        e.rev_cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic step(input logic r, input logic s, input logic h, input logic a,
                        input logic [7:0] rv, input logic l, input logic [7:0] lv);
        @(negedge clk);
        reset = r; start = s; hold = h; abort = a; revs = rv; load = l; load_val = lv;
        model_step(r, s, h, a, rv, l, lv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            mon_a = '{q: q, phase: phase, busy: busy, done: done, err: err, rev_cnt: rev_cnt};
            vectors++;
            if (mon_a !== mon_e) begin
                miscompares++;
                $display("FAIL outputs vec%0d t=%0t: got q=%h phase=%h busy=%b done=%b err=%b rev_cnt=%0d, want q=%h phase=%h busy=%b done=%b err=%b rev_cnt=%0d",
                         vectors, $time, mon_a.q, mon_a.phase, mon_a.busy, mon_a.done,
                         mon_a.err, mon_a.rev_cnt, mon_e.q, mon_e.phase, mon_e.busy,
                         mon_e.done, mon_e.err, mon_e.rev_cnt);
            end
        end
    end

    initial begin
        int t;
        logic [7:0] lv;
        for (int k = 0; k < 16; k++) begin
            t = (k <= 8) ? ((1 << k) - 1) : ((255 << (k - 8)) & 255);
            codes[k] = t[7:0];
        end
        m_q = 8'h00; m_mode = 0; m_revs = 8'h00; m_cnt = 8'h00; m_err = 1'b0;
        reset = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0;
        revs = 8'd0; load = 1'b0; load_val = 8'd0;

        // Reset, then a single one-revolution run.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 8'd0);
        idle(20);

        // Three revolutions with a five-cycle hold mid-run.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 8'd0);
        idle(20);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        idle(35);

        // Abort after seven advances; then start+abort together in idle.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 8'd0);
        idle(7);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 8'd0);
        idle(3);

        // Legal preload with start; then start during the done cycle is ignored.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 8'hF8);
        idle(4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 8'h0F);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 8'h00);
        idle(20);

        // Illegal preload, then a run that repairs the code.
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h55);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 8'h00);
        idle(20);

        // Free-run through 256 revolutions, then reset mid-run.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00);
        idle(256 * 16 + 9);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            lv = ($urandom_range(1) == 0) ? codes[$urandom_range(15)] : 8'($urandom);
            step($urandom_range(299) == 0, $urandom_range(3) == 0, $urandom_range(4) == 0,
                 $urandom_range(59) == 0, 8'($urandom_range(3)), $urandom_range(9) == 0, lv);
        end

        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/johnson_seq_ctrl.md
# johnson_seq_ctrl

Sequencing controller for the 8-bit Johnson counter datapath. It owns the 16-state Johnson register and runs it for a programmed number of full revolutions. It supports hold, abort and preload, decodes the current state into a one-hot phase bus for downstream slot scheduling, and detects and recovers from illegal register codes. It sits between the system control logic (start/abort) and the phase-driven consumers.

## Interface
- `WIDTH`, 8, Johnson register width; state count is 2*WIDTH = 16.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled in IDLE only.
- `hold`  in  1  freeze the register while in RUN.
- `abort`  in  1  terminate a run immediately, with no `done`.
- `revs`  in  8  revolutions per run, latched on an accepted start; 0 = free-run until abort.
- `load`  in  1  preload the register; honoured in IDLE only.
- `load_val`  in  8  preload value.
- `q`  out  8  Johnson register.
- `phase`  out  16  one-hot decode of `q`; all zero when not in RUN or when `q` is illegal.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `err`  out  1  sticky illegal-code flag.
- `rev_cnt`  out  8  revolutions completed in the current or last run.

## Operation
- **Advance:** `q <= {q[6:0], ~q[7]}`.
- **Legal sequence:** 00000000, 00000001, 00000011 … 11111111, 11111110 … 10000000, then back to 00000000.
- **Phase index k:**
  - for k ≤ 8, `q` holds k ones in its LSBs;
  - for k > 8, `q` holds (16−k) ones in its MSBs;
  - `phase[k]` = 1.
- **Legality:** exactly the 16 codes above are legal; the other 240 are illegal.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `abort` = 1 → stay in IDLE; `abort` overrides `start`.
  - Otherwise `start` = 1 → go to RUN, latch `revs`, clear `rev_cnt` to 0.
  - `load` = 1 → `q <= load_val`. This also applies in a cycle where `start` is accepted, so the run begins from the loaded value.
  - Without `load`, `q` holds its value.
- **RUN:**
  - `abort` → go to IDLE and set `q` to 0. `abort` has priority over `hold` and the advance.
  - Else if `hold` → `q` and `rev_cnt` hold.
  - Else if `q` is illegal → `q <= 0` (correction replaces the advance).
  - Else → advance.
  - `start` and `load` are ignored.
- **Revolution:** counted on the advance 10000000 → 00000000, which increments `rev_cnt`.
  - Counting is by wrap only. A run started from a preloaded nonzero state has a shorter first revolution.
  - With `revs` ≠ 0: when the incremented `rev_cnt` equals the latched `revs`, go to DONE at the same edge.
  - With `revs` = 0: `rev_cnt` wraps 255 → 0 and the run continues.
- **DONE:** `done` = 1, `busy` = 0, `q` = 0; go to IDLE on the next edge. Inputs are ignored.
- **Error flag:** `err` is set at any edge where `q` is illegal, in any state. It is cleared only by `reset`.
- **Reset values:** `q`, `phase` and `rev_cnt` = 0; `busy`, `done` and `err` = 0; state IDLE.
  - Reset has priority over every input and takes effect mid-run, with no `done`.

## Timing
- All outputs are registered or decoded from registered state. `phase` is combinational from `q` and the FSM state.
- **Start:** `start` sampled at edge E0 → `busy` = 1 from E0. The first advance occurs at E1 (`q` = 00000001 after E1 when starting from 0).
- **Run length:** a run from 0 with `revs` = N, and no hold, takes 16N advances. The last advance is at edge E(16N); DONE follows it, `done` is high for the cycle after it, and the FSM is back in IDLE after E(16N+1).
- **Hold:** each cycle with `hold` = 1 in RUN extends the run by exactly one cycle.
- **Abort:** `abort` sampled at edge E → `busy` = 0 and `q` = 0 after E; `done` never asserts.
- **Correction:** illegal `q` at a RUN edge → `q` = 0 and `err` = 1 after that edge. Normal advances resume on the next edge.
- **Back-to-back runs:** `start` in the DONE cycle is ignored. The earliest accepted restart is the first IDLE cycle.

## Test plan
- **Reset then single run:** `start` with `revs` = 1 → `q` steps through all 16 legal codes; `phase` walks bit 0 → 15 → 0; `done` pulses once 17 cycles after the start edge; `rev_cnt` = 1; `err` = 0.
- **Multi-revolution with hold:** `revs` = 3, `hold` asserted for 5 cycles mid-run → `done` at 48 + 5 + 1 cycles after the start edge; `rev_cnt` = 3.
- **Abort mid-run:** abort after 7 advances (`q` = 01111111) → `q` = 0, `busy` = 0 next cycle, no `done`. Also drive `start` and `abort` together in IDLE → remains IDLE.
- **Preload legal value:** `load_val` = 11111000 together with `start`, `revs` = 1 → first wrap after 5 advances, then `done`; `rev_cnt` = 1.
- **Illegal preload:** `load_val` = 01010101 in IDLE → `err` = 1 after the next edge, `phase` = 0. Then `start` → `q` = 0 after the first RUN edge and the run completes normally with `err` still 1.
- **Free-run and reset mid-run:** `revs` = 0, run 256 revolutions → `rev_cnt` wraps to 0 with no `done`. Then assert `reset` mid-run → all outputs return to 0 the next cycle.
